cpu_clock_controller: RTL and testbench
=======================================

// Module: cpu_clock_controller
// PURPOSE
//   Sequences the pipeline CPU's execution rate via a single-cycle clock-enable (cpu_en) on the 100 MHz system clock.
//   Modes: halt, single-step (debounced button), slow (one enable per SLOW_PERIOD cycles), full run.
//   Also traps on a CPU halt request and resumes on command.
//   Sits between the board I/O (switches/buttons) and the CPU top; the CPU gates every state update with cpu_en.
// PARAMETERS
//   SLOW_PERIOD      100_000_000  cycles between enables in SLOW mode (1 Hz at 100 MHz); legal >= 2
//   DEBOUNCE_CYCLES  1_000_000    cycles step_btn must be stable before a level change is accepted; legal >= 1
// PORTS
//   clk         in   1   100 MHz system clock
//   reset       in   1   asynchronous, active-low reset
//   mode        in   2   00 HALT, 01 STEP, 10 SLOW, 11 RUN (quasi-static switches)
//   step_btn    in   1   raw asynchronous push button, active-high
//   halt_req    in   1   CPU requests stop (e.g. halt instruction retired), synchronous, level
//   resume      in   1   leave TRAP state, synchronous, level
//   cpu_en      out  1   registered clock-enable to CPU; one enable per high cycle
//   state       out  3   current FSM state encoding (debug LEDs)
//   trapped     out  1   high while in TRAP
//   tick_count  out  32  number of cpu_en-high cycles since reset, wraps 2^32-1 -> 0
// BEHAVIOUR
//   Reset (reset=0, async):
//   - state=IDLE(0), cpu_en=0, trapped=0, tick_count=0.
//   - Slow and debounce counters clear to 0; synchronizer and debounced level clear to 0.
//   FSM states: IDLE=0, STEP=1, SLOW=2, RUN=3, TRAP=4. All outputs registered.
//   Mode tracking (any non-TRAP state):
//   - Next state = state selected by mode (00->IDLE, 01->STEP, 10->SLOW, 11->RUN).
//   - A mode change takes effect on the next clock edge.
//   Priority each edge: halt_req (non-TRAP) > resume (TRAP) > mode tracking.
//   halt_req=1 in a non-TRAP state:
//   - Next state TRAP; cpu_en=0 from the following cycle.
//   - An enable already registered for the current cycle is not retracted.
//   TRAP:
//   - cpu_en=0; trapped=1. halt_req is ignored; mode changes are ignored.
//   - resume=1 -> next state from mode and trapped=0, taking effect the same edge.
//   - resume and halt_req both high in TRAP: resume wins. If halt_req is still high one cycle later, the block re-traps.
//   cpu_en generation (value registered for the next cycle):
//   - IDLE: 0.
//   - RUN: 1 every cycle while in RUN; the first high cycle is the cycle after RUN is entered.
//   - SLOW:
//     - Counter clears on SLOW entry and counts 0..SLOW_PERIOD-1, then wraps to 0.
//     - cpu_en=1 for exactly one cycle, the cycle after the counter reaches SLOW_PERIOD-1.
//     - First pulse comes SLOW_PERIOD cycles after entry.
//     - Leaving SLOW clears the counter.
//   - STEP: one-cycle pulse per accepted rising edge of the debounced button (see step path).
//   Step path:
//   - step_btn passes through a 2-FF synchronizer.
//   - The debounce counter resets on every synchronized level change.
//   - When the counter reaches DEBOUNCE_CYCLES, the debounced level adopts the synchronized level.
//   - The debounce path runs in all states, so a press held in another state gives no pulse on entering STEP; only a fresh 0->1 does.
//   - Latency from a clean step_btn rise to cpu_en is 2 + DEBOUNCE_CYCLES + 1 cycles.
//   - Holding the button yields exactly one pulse.
//   tick_count: +1 on every cycle cpu_en=1; mod 2^32 wrap with no flag.
//   Reset mid-operation:
//   - Immediate async clear of all state.
//   - cpu_en drops without waiting for a clock edge.
// TESTING (bench params SLOW_PERIOD=4, DEBOUNCE_CYCLES=3)
//   1. Reset, mode=11 for 10 cycles -> cpu_en low the first cycle after entry, then high 9 cycles; tick_count=9.
//   2. mode=10 for 13 cycles -> cpu_en high exactly on cycles 4, 8 and 12 after entry; tick_count=3.
//   3. mode=01, step_btn glitch 1 cycle, then a clean press held 20 cycles -> exactly one cpu_en pulse, 6 cycles after the clean rise.
//   4. RUN, halt_req=1 for 1 cycle -> state=TRAP next edge, trapped=1, cpu_en=0 after at most one in-flight cycle.
//      mode toggles while trapped -> no change. resume=1 -> RUN.
//   5. TRAP with resume=1 and halt_req=1 together -> leaves TRAP.
//      halt_req still high next cycle -> TRAP again; check the state sequence 4->3->4.
//   6. Force tick_count to 32'hFFFF_FFFF in RUN, then reset=0 asynchronously mid-cycle.
//      Check: one more enable wraps tick_count to 0; all outputs clear immediately on reset.

Source files
------------

// File: rtl/cpu_clock_controller_if.sv
// rtl/cpu_clock_controller_if.sv - board-side control and CPU-side enable/status bundle
interface cpu_clock_controller_if;
  logic [1:0]  mode;
  logic        step_btn;
  logic        halt_req;
  logic        resume;
  logic        cpu_en;
  logic [2:0]  state;
  logic        trapped;
  logic [31:0] tick_count;

  // Board/bench side: drives switches, button and CPU requests; observes enable and status
  modport master (
    output mode, step_btn, halt_req, resume,
    input  cpu_en, state, trapped, tick_count
  );

  // Controller side
  modport slave (
    input  mode, step_btn, halt_req, resume,
    output cpu_en, state, trapped, tick_count
  );
endinterface

// File: rtl/cpu_clock_controller.sv
// rtl/cpu_clock_controller.sv - CPU clock-enable sequencer (halt/step/slow/run with trap)
module cpu_clock_controller #(
  parameter int unsigned SLOW_PERIOD     = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_clock_controller_if.slave bus
);

  localparam int unsigned SLOW_W = $clog2(SLOW_PERIOD);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_PERIOD - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_STEP = 3'd1,
    ST_SLOW = 3'd2,
    ST_RUN  = 3'd3,
    ST_TRAP = 3'd4
  } state_t;

  state_t              state_q;
  state_t              mode_state;
  state_t              next_state;
  logic                cpu_en_q;
  logic                trapped_q;
  logic                en_next;
  logic [31:0]         tick_q;
  logic [SLOW_W-1:0]   slow_cnt_q;
  logic [1:0]          sync_q;
  logic [DEB_W-1:0]    deb_cnt_q;
  logic                deb_level_q;
  logic                step_accept;

  // A debounced 0->1 is accepted on the edge where the counter has seen DEBOUNCE_CYCLES stable cycles
  assign step_accept = sync_q[1] & ~deb_level_q & (deb_cnt_q == DEB_MAX);

  // Next state with priority halt_req > resume > mode; enable is only issued when staying in the same state
  always_comb begin
    mode_state = ST_IDLE;
    case (bus.mode)
      2'b01:   mode_state = ST_STEP;
      2'b10:   mode_state = ST_SLOW;
      2'b11:   mode_state = ST_RUN;
      default: mode_state = ST_IDLE;
    endcase

    next_state = mode_state;
    if (state_q == ST_TRAP) begin
      if (!bus.resume) next_state = ST_TRAP;
    end else if (bus.halt_req) begin
      next_state = ST_TRAP;
    end

    en_next = 1'b0;
    if (next_state == state_q) begin
      case (state_q)
        ST_RUN:  en_next = 1'b1;
        ST_SLOW: en_next = (slow_cnt_q == SLOW_LAST);
        ST_STEP: en_next = step_accept;
        default: en_next = 1'b0;
      endcase
    end
  end

  // Main FSM with registered enable and trap flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cpu_en_q  <= 1'b0;
      trapped_q <= 1'b0;
    end else begin
      state_q   <= next_state;
      cpu_en_q  <= en_next;
      trapped_q <= (next_state == ST_TRAP);
    end
  end

  // Slow-mode divider: runs only while SLOW persists, cleared on entry and exit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slow_cnt_q <= '0;
    end else if (state_q == ST_SLOW && next_state == ST_SLOW) begin
      slow_cnt_q <= (slow_cnt_q == SLOW_LAST) ? '0 : slow_cnt_q + 1'b1;
    end else begin
      slow_cnt_q <= '0;
    end
  end

  // Button synchronizer and debouncer, active in every state so stale presses never fire on STEP entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= 2'b00;
      deb_cnt_q   <= '0;
      deb_level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], bus.step_btn};
      if (sync_q[1] == deb_level_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_MAX) begin
        deb_level_q <= sync_q[1];
        deb_cnt_q   <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  // Count completed enable cycles; wraps silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + 32'(cpu_en_q);
    end
  end

  assign bus.cpu_en     = cpu_en_q;
  assign bus.state      = state_q;
  assign bus.trapped    = trapped_q;
  assign bus.tick_count = tick_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// tb/tb_cpu_clock_controller.sv - scoreboard bench for cpu_clock_controller
module tb_cpu_clock_controller;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  typedef struct packed {
    logic [2:0]  st;
    logic        en;
    logic        trp;
    logic [31:0] tick;
  } exp_t;

  exp_t        sb[$];
  string       tag_q[$];
  exp_t        mon_e;
  string       mon_tag;
  logic [31:0] exp_tick;
  logic        prev_en;

  cpu_clock_controller_if bus();

  cpu_clock_controller #(
    .SLOW_PERIOD     (4),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at a negedge and queue what the outputs must be after the next posedge
  task automatic cyc(input logic [1:0] m, input logic btn, input logic hr, input logic rs,
                     input logic [2:0] es, input logic ee, input string tag);
    exp_t e;
    bus.mode     = m;
    bus.step_btn = btn;
    bus.halt_req = hr;
    bus.resume   = rs;
    exp_tick = exp_tick + 32'(prev_en);
    prev_en  = ee;
    e.st   = es;
    e.en   = ee;
    e.trp  = (es == 3'd4);
    e.tick = exp_tick;
    sb.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per edge while the scoreboard holds entries
  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_tag = tag_q.pop_front();
      check_eq({mon_tag, ".state"},   32'(bus.state),   32'(mon_e.st));
      check_eq({mon_tag, ".cpu_en"},  32'(bus.cpu_en),  32'(mon_e.en));
      check_eq({mon_tag, ".trapped"}, 32'(bus.trapped), 32'(mon_e.trp));
      check_eq({mon_tag, ".tick"},    bus.tick_count,   mon_e.tick);
    end
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    exp_tick = '0;
    prev_en  = 1'b0;
    reset        = 1'b0;
    bus.mode     = 2'b00;
    bus.step_btn = 1'b0;
    bus.halt_req = 1'b0;
    bus.resume   = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst.state",   32'(bus.state),   32'd0);
    check_eq("rst.cpu_en",  32'(bus.cpu_en),  32'd0);
    check_eq("rst.trapped", 32'(bus.trapped), 32'd0);
    check_eq("rst.tick",    bus.tick_count,   32'd0);
    reset = 1'b1;
    cyc(2'b00, 0, 0, 0, 3'd0, 0, "idle");

    // RUN: first cycle low, then nine enables
    cyc(2'b11, 0, 0, 0, 3'd3, 0, "run0");
    for (int k = 1; k < 10; k++) cyc(2'b11, 0, 0, 0, 3'd3, 1, "run");
    cyc(2'b00, 0, 0, 0, 3'd0, 0, "run_exit");

    // SLOW: pulses on cycles 4, 8, 12 after entry
    for (int k = 0; k < 13; k++) cyc(2'b10, 0, 0, 0, 3'd2, (k != 0 && k % 4 == 0), "slow");
    cyc(2'b00, 0, 0, 0, 3'd0, 0, "slow_exit");

    // STEP: one-cycle glitch rejected, clean held press gives one pulse 6 cycles after the rise
    for (int k = 0; k < 3; k++) cyc(2'b01, 0, 0, 0, 3'd1, 0, "step_wait");
    cyc(2'b01, 1, 0, 0, 3'd1, 0, "glitch");
    for (int k = 0; k < 8; k++) cyc(2'b01, 0, 0, 0, 3'd1, 0, "glitch_quiet");
    for (int k = 1; k <= 20; k++) cyc(2'b01, 1, 0, 0, 3'd1, (k == 6), "press");
    for (int k = 0; k < 8; k++) cyc(2'b01, 0, 0, 0, 3'd1, 0, "release");

    // Press held in IDLE, still held on STEP entry: no pulse
    for (int k = 0; k < 10; k++) cyc(2'b00, 1, 0, 0, 3'd0, 0, "held_idle");
    for (int k = 0; k < 5; k++) cyc(2'b01, 1, 0, 0, 3'd1, 0, "held_step");
    for (int k = 0; k < 8; k++) cyc(2'b01, 0, 0, 0, 3'd1, 0, "held_release");
    cyc(2'b00, 0, 0, 0, 3'd0, 0, "step_exit");

    // Halt from RUN, mode changes ignored in TRAP, resume back to RUN
    cyc(2'b11, 0, 0, 0, 3'd3, 0, "h_run0");
    for (int k = 0; k < 3; k++) cyc(2'b11, 0, 0, 0, 3'd3, 1, "h_run");
    cyc(2'b11, 0, 1, 0, 3'd4, 0, "halt");
    cyc(2'b00, 0, 0, 0, 3'd4, 0, "trap_m0");
    cyc(2'b10, 0, 0, 0, 3'd4, 0, "trap_m2");
    cyc(2'b01, 0, 1, 0, 3'd4, 0, "trap_m1_halt");
    cyc(2'b11, 0, 0, 0, 3'd4, 0, "trap_m3");
    cyc(2'b11, 0, 0, 1, 3'd3, 0, "resume");
    cyc(2'b11, 0, 0, 0, 3'd3, 1, "res_run");
    cyc(2'b11, 0, 0, 0, 3'd3, 1, "res_run");

    // resume and halt_req together: leave TRAP, then re-trap (4 -> 3 -> 4)
    cyc(2'b11, 0, 1, 0, 3'd4, 0, "halt2");
    cyc(2'b11, 0, 1, 1, 3'd3, 0, "both");
    cyc(2'b11, 0, 1, 0, 3'd4, 0, "retrap");
    cyc(2'b11, 0, 0, 1, 3'd3, 0, "resume2");
    cyc(2'b11, 0, 0, 0, 3'd3, 1, "run2");

    // tick_count wrap: preload all-ones while an enable is in flight
    dut.tick_q <= 32'hFFFF_FFFF;
    exp_tick = 32'hFFFF_FFFF;
    cyc(2'b11, 0, 0, 0, 3'd3, 1, "wrap");
    cyc(2'b11, 0, 0, 0, 3'd3, 1, "wrap_next");

    // Async reset mid-cycle while enabled
    @(posedge clk);
    #2;
    check_eq("pre_rst.cpu_en", 32'(bus.cpu_en), 32'd1);
    check_eq("pre_rst.tick",   bus.tick_count,  32'd2);
    #1;
    reset = 1'b0;
    #1;
    check_eq("arst.state",   32'(bus.state),   32'd0);
    check_eq("arst.cpu_en",  32'(bus.cpu_en),  32'd0);
    check_eq("arst.trapped", 32'(bus.trapped), 32'd0);
    check_eq("arst.tick",    bus.tick_count,   32'd0);
    check_eq("sb_drain",     32'(sb.size()),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
